// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, state codes,
// ALU operation and ALU B-source selects.
package mc_control_fsm_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADI  = 4'b0001;
  localparam logic [3:0] OP_NAND = 4'b0010;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1001;
  localparam logic [3:0] OP_LW   = 4'b1010;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_WB_ALU   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_WB_MEM   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_HALT     = 4'd15
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_NAND  = 2'b10;
  localparam logic [1:0] ALU_PASSB = 2'b11;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  function automatic logic is_rtype(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_NAND);
  endfunction

endpackage

// File: rtl/mc_cond_eval.sv
// Condition evaluation for ADD/NAND conditional execution on the stored
// zero/carry flags; non-R-type instructions always execute.
module mc_cond_eval
  import mc_control_fsm_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [1:0] cz,
  input  logic       zero,
  input  logic       carry,
  output logic       cond,
  output logic       cz_illegal
);

  logic rtype;

  assign rtype      = is_rtype(opcode);
  assign cz_illegal = rtype && (cz == 2'b11);

  always_comb begin
    cond = 1'b1;
    if (rtype) begin
      case (cz)
        2'b00:   cond = 1'b1;
        2'b10:   cond = carry;
        2'b01:   cond = zero;
        default: cond = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control FSM for the 16-bit core. Define ILLEGAL_HALT_EN to make
// an illegal opcode enter a sticky HALT state instead of being skipped.
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter int STATE_W = 4,
  parameter int ALUOP_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         opcode,
  input  logic [1:0]         cz,
  input  logic               zero,
  input  logic               carry,
  input  logic               alu_zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_src,
  output logic               ir_write,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               result_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               flag_write,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  state_t state_reg, state_next;
  logic   cond_reg;
  logic   cond, cz_illegal;

  mc_cond_eval u_cond (
    .opcode     (opcode),
    .cz         (cz),
    .zero       (zero),
    .carry      (carry),
    .cond       (cond),
    .cz_illegal (cz_illegal)
  );

  // Condition is frozen at DECODE so the flag update in EXEC_R cannot
  // change whether the same instruction writes back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_FETCH;
      cond_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_DECODE) cond_reg <= cond;
    end
  end

  assign state = STATE_W'(state_reg);

  always_comb begin
    state_next = state_reg;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    result_src = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALUOP_W'(ALU_ADD);
    flag_write = 1'b0;
    illegal    = 1'b0;

    case (state_reg)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_ONE;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_ADD, OP_NAND: state_next = cz_illegal ? S_FETCH : S_EXEC_R;
          OP_ADI:          state_next = S_EXEC_I;
          OP_LW, OP_SW:    state_next = S_MEM_ADDR;
          OP_BEQ:          state_next = S_BRANCH;
          default:         state_next = S_FETCH;
        endcase
        if (cz_illegal || !(is_rtype(opcode) || opcode == OP_ADI || opcode == OP_LW
                            || opcode == OP_SW || opcode == OP_BEQ)) begin
          illegal = 1'b1;
`ifdef ILLEGAL_HALT_EN
          state_next = S_HALT;
`else
          state_next = S_FETCH;
`endif
        end
      end
      S_EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_op     = ALUOP_W'((opcode == OP_NAND) ? ALU_NAND : ALU_ADD);
        flag_write = cond_reg;
        state_next = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        flag_write = 1'b1;
        state_next = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_dst    = (opcode == OP_ADI);
        reg_write  = cond_reg;
        state_next = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        state_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_next = S_WB_MEM;
      end
      S_WB_MEM: begin
        reg_dst    = 1'b1;
        result_src = 1'b1;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALUOP_W'(ALU_SUB);
        pc_src     = 1'b1;
        pc_write   = alu_zero;
        state_next = S_FETCH;
      end
`ifdef ILLEGAL_HALT_EN
      S_HALT: begin
        illegal    = 1'b1;
        state_next = S_HALT;
      end
`endif
      default: state_next = S_FETCH;
    endcase

    // Asserting reset kills any in-flight request without waiting for a clock.
    if (reset) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      flag_write = 1'b0;
      illegal    = 1'b0;
      alu_src_b  = SRCB_REG;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class cycle by
// cycle and checks state plus every control output against hand-derived values.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic [1:0] cz = 2'b00;
  logic       zero = 1'b0;
  logic       carry = 1'b0;
  logic       alu_zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_src, ir_write, iord, mem_read, mem_write;
  logic       reg_write, reg_dst, result_src, alu_src_a, flag_write, illegal;
  logic [1:0] alu_src_b, alu_op;
  logic [3:0] state;
  logic [15:0] obs;

  int n_cmp = 0;
  int n_err = 0;

  mc_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .cz(cz), .zero(zero),
    .carry(carry), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .flag_write(flag_write),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // Bit order: pw ps irw iord | mr mw rw rd | rs asa asb[1:0] | aop[1:0] fw ill
  assign obs = {pc_write, pc_src, ir_write, iord, mem_read, mem_write,
                reg_write, reg_dst, result_src, alu_src_a, alu_src_b,
                alu_op, flag_write, illegal};

  task automatic check_now(input string tag, input logic [3:0] es, input logic [15:0] ev);
    n_cmp++;
    assert (state === es) else begin
      n_err++;
      $error("FAIL %s state: observed %0d expected %0d", tag, state, es);
    end
    n_cmp++;
    assert (obs === ev) else begin
      n_err++;
      $error("FAIL %s outputs: observed %04h expected %04h", tag, obs, ev);
    end
    $display("%s: state=%0d outputs=%04h", tag, state, obs);
  endtask

  task automatic cyc(input string tag, input logic mr, input logic [3:0] es, input logic [15:0] ev);
    @(negedge clk);
    mem_ready = mr;
    #1;
    check_now(tag, es, ev);
  endtask

  initial begin
    // Held in reset: FETCH with every output low
    #3;
    check_now("reset", 4'd0, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    // ADD 02a0, cz=00
    opcode = 4'b0000; cz = 2'b00;
    cyc("add.fetch",  1'b1, 4'd0, 16'hA810);
    cyc("add.decode", 1'b1, 4'd1, 16'h0020);
    cyc("add.exec",   1'b1, 4'd2, 16'h0042);
    cyc("add.wb",     1'b1, 4'd4, 16'h0200);

    // LW a454 with two memory wait cycles
    opcode = 4'b1010; cz = 2'b00;
    cyc("lw.fetch",   1'b1, 4'd0, 16'hA810);
    cyc("lw.decode",  1'b1, 4'd1, 16'h0020);
    cyc("lw.addr",    1'b1, 4'd5, 16'h0060);
    cyc("lw.rd0",     1'b0, 4'd6, 16'h1800);
    cyc("lw.rd1",     1'b0, 4'd6, 16'h1800);
    cyc("lw.rd2",     1'b1, 4'd6, 16'h1800);
    cyc("lw.wb",      1'b1, 4'd7, 16'h0380);

    // SW 9c4c with one fetch wait and one write wait
    opcode = 4'b1001;
    cyc("sw.fetchw",  1'b0, 4'd0, 16'h0810);
    cyc("sw.fetch",   1'b1, 4'd0, 16'hA810);
    cyc("sw.decode",  1'b1, 4'd1, 16'h0020);
    cyc("sw.addr",    1'b1, 4'd5, 16'h0060);
    cyc("sw.wr0",     1'b0, 4'd8, 16'h1400);
    cyc("sw.wr1",     1'b1, 4'd8, 16'h1400);

    // ADD cz=10 with carry=0: squashed
    opcode = 4'b0000; cz = 2'b10; carry = 1'b0;
    cyc("addc0.fetch",  1'b1, 4'd0, 16'hA810);
    cyc("addc0.decode", 1'b1, 4'd1, 16'h0020);
    cyc("addc0.exec",   1'b1, 4'd2, 16'h0040);
    cyc("addc0.wb",     1'b1, 4'd4, 16'h0000);

    // ADD cz=10 with carry=1: executes
    carry = 1'b1;
    cyc("addc1.fetch",  1'b1, 4'd0, 16'hA810);
    cyc("addc1.decode", 1'b1, 4'd1, 16'h0020);
    cyc("addc1.exec",   1'b1, 4'd2, 16'h0042);
    cyc("addc1.wb",     1'b1, 4'd4, 16'h0200);
    carry = 1'b0;

    // NAND cz=01 with zero=1: executes with nand op
    opcode = 4'b0010; cz = 2'b01; zero = 1'b1;
    cyc("nandz.fetch",  1'b1, 4'd0, 16'hA810);
    cyc("nandz.decode", 1'b1, 4'd1, 16'h0020);
    cyc("nandz.exec",   1'b1, 4'd2, 16'h004A);
    cyc("nandz.wb",     1'b1, 4'd4, 16'h0200);

    // NAND cz=01 with zero=0: squashed
    zero = 1'b0;
    cyc("nand0.fetch",  1'b1, 4'd0, 16'hA810);
    cyc("nand0.decode", 1'b1, 4'd1, 16'h0020);
    cyc("nand0.exec",   1'b1, 4'd2, 16'h0048);
    cyc("nand0.wb",     1'b1, 4'd4, 16'h0000);

    // ADI writes ra
    opcode = 4'b0001; cz = 2'b11;
    cyc("adi.fetch",  1'b1, 4'd0, 16'hA810);
    cyc("adi.decode", 1'b1, 4'd1, 16'h0020);
    cyc("adi.exec",   1'b1, 4'd3, 16'h0062);
    cyc("adi.wb",     1'b1, 4'd4, 16'h0300);

    // BEQ taken then not taken
    opcode = 4'b1000; cz = 2'b00; alu_zero = 1'b1;
    cyc("beq1.fetch",  1'b1, 4'd0, 16'hA810);
    cyc("beq1.decode", 1'b1, 4'd1, 16'h0020);
    cyc("beq1.branch", 1'b1, 4'd9, 16'hC044);
    alu_zero = 1'b0;
    cyc("beq0.fetch",  1'b1, 4'd0, 16'hA810);
    cyc("beq0.decode", 1'b1, 4'd1, 16'h0020);
    cyc("beq0.branch", 1'b1, 4'd9, 16'h4044);

    // ADD with cz=11 is illegal
    opcode = 4'b0000; cz = 2'b11;
    cyc("cz11.fetch",  1'b1, 4'd0, 16'hA810);
    cyc("cz11.decode", 1'b1, 4'd1, 16'h0021);
`ifdef ILLEGAL_HALT_EN
    cyc("cz11.halt",   1'b1, 4'd15, 16'h0001);
    reset = 1'b1;
    #1;
    check_now("cz11.rst", 4'd0, 16'h0000);
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b0;
`endif

    // Opcode 1111 is illegal
    opcode = 4'b1111; cz = 2'b00;
    cyc("ill.fetch",  1'b1, 4'd0, 16'hA810);
    cyc("ill.decode", 1'b1, 4'd1, 16'h0021);
`ifdef ILLEGAL_HALT_EN
    cyc("ill.halt0",  1'b1, 4'd15, 16'h0001);
    cyc("ill.halt1",  1'b1, 4'd15, 16'h0001);
    reset = 1'b1;
    #1;
    check_now("ill.rst", 4'd0, 16'h0000);
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b0;
    cyc("ill.after",  1'b0, 4'd0, 16'h0810);
`else
    cyc("ill.after",  1'b0, 4'd0, 16'h0810);
`endif

    // Reset asserted mid read-wait drops mem_read at once
    opcode = 4'b1010;
    cyc("abort.fetch",  1'b1, 4'd0, 16'hA810);
    cyc("abort.decode", 1'b1, 4'd1, 16'h0020);
    cyc("abort.addr",   1'b1, 4'd5, 16'h0060);
    cyc("abort.rd",     1'b0, 4'd6, 16'h1800);
    reset = 1'b1;
    #1;
    check_now("abort.rst", 4'd0, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    cyc("abort.fetch2", 1'b1, 4'd0, 16'hA810);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle control unit for the 16-bit processor core (`multi_cycle`).
- Sequences fetch, decode, execute, memory and writeback for each instruction.
- Drives datapath enables and muxes and handles the memory-ready handshake.
- Implements ADD/NAND conditional execution on the zero and carry flags.

Parameters:
- STATE_W, 4, width of the exported state code.
- ALUOP_W, 2, width of alu_op.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  4  instr[15:12] from the instruction register.
- cz  in  2  instr[1:0], condition field.
- zero  in  1  stored zero flag.
- carry  in  1  stored carry flag.
- alu_zero  in  1  combinational ALU zero (used by BEQ compare).
- mem_ready  in  1  memory completes the access this cycle.
- pc_write  out  1  PC load enable.
- pc_src  out  1  0 = ALU result, 1 = aluout register (branch target).
- ir_write  out  1  instruction register load.
- iord  out  1  memory address: 0 = PC, 1 = aluout.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  destination: 0 = rc (instr[5:3]), 1 = ra (instr[11:9]).
- result_src  out  1  writeback source: 0 = aluout, 1 = memory data register.
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = register A.
- alu_src_b  out  2  ALU B input: 00 = register B, 01 = constant 1, 10 = sext(imm6).
- alu_op  out  ALUOP_W  00 = add, 01 = sub, 10 = nand, 11 = pass B.
- flag_write  out  1  update stored zero/carry flags.
- illegal  out  1  unrecognised opcode seen.
- state  out  STATE_W  current state code, for debug.

Behaviour:
- Opcodes:
  - ADD 0000
  - ADI 0001
  - NAND 0010
  - BEQ 1000
  - SW 1001
  - LW 1010
  - all others are illegal.
- Reset (asynchronous, active-high): state = FETCH(0). All registered outputs are 0 and illegal = 0. Outputs are Moore-decoded from state, except the conditional write noted below.
- FETCH(0):
  - Drive iord = 0, mem_read = 1, ir_write = mem_ready, alu_src_a = 0, alu_src_b = 01, alu_op = add, pc_src = 0, pc_write = mem_ready.
  - Stay in FETCH while mem_ready = 0; go to DECODE when mem_ready = 1.
  - ir_write and pc_write are asserted only in the cycle where mem_ready = 1.
- DECODE(1):
  - Compute the branch target: alu_src_a = 0, alu_src_b = 10, alu_op = add; aluout captures PC + imm.
  - Dispatch: ADD/NAND → EXEC_R, ADI → EXEC_I, LW/SW → MEM_ADDR, BEQ → BRANCH, illegal → FETCH.
- EXEC_R(2): alu_src_a = 1, alu_src_b = 00, alu_op = add or nand, flag_write = 1 unless the instruction is squashed. Next state WB_ALU.
- EXEC_I(3): alu_src_a = 1, alu_src_b = 10, alu_op = add, flag_write = 1. Next state WB_ALU.
- WB_ALU(4): result_src = 0, reg_dst = 1 for ADI and 0 otherwise, reg_write = cond. Next state FETCH.
- MEM_ADDR(5): alu_src_a = 1 (register B drives port A per datapath wiring), alu_src_b = 10, alu_op = add. Next state MEM_RD for LW, MEM_WR for SW.
- MEM_RD(6): iord = 1, mem_read = 1. Hold until mem_ready = 1, then go to WB_MEM.
- WB_MEM(7): reg_dst = 1, result_src = 1, reg_write = 1. Next state FETCH.
- MEM_WR(8): iord = 1, mem_write = 1. Hold until mem_ready = 1, then go to FETCH. mem_write stays high throughout the wait.
- BRANCH(9): alu_src_a = 1, alu_src_b = 00, alu_op = sub, pc_src = 1, pc_write = alu_zero. Next state FETCH.
- Conditional execution (cond) for ADD/NAND:
  - cz = 00 → always.
  - cz = 10 → only if carry = 1.
  - cz = 01 → only if zero = 1.
  - cz = 11 → treated as illegal in DECODE.
  - A squashed instruction still takes all cycles, with reg_write = 0 and flag_write = 0.
- Cycle counts with mem_ready always 1:
  - ADD/NAND/ADI: 4.
  - LW: 5.
  - SW: 4.
  - BEQ: 3.
  - Each memory wait cycle adds 1.
- An illegal opcode sets illegal = 1 for one cycle (DECODE) and goes to FETCH. No register, memory or flag write occurs.
- Reset mid-access immediately aborts: mem_read and mem_write drop asynchronously.

Optional Feature:
- Macro: ILLEGAL_HALT_EN.
- Defined: an illegal opcode moves to HALT(15). HALT is sticky; all enables are 0 and illegal = 1 until reset.
- Undefined: illegal opcodes are skipped as described above, and HALT is unreachable.

Decomposition:
- Shared package holds:
  - opcode constants (OP_ADD, OP_ADI, OP_NAND, OP_BEQ, OP_SW, OP_LW);
  - the state enum codes;
  - alu_op and alu_src_b encodings.
- Natural sub-module: mc_cond_eval, combinational; takes opcode, cz, zero and carry and produces cond and cz_illegal.

Test Plan:
- Reset, then fetch 02a0 (ADD cz = 00) with mem_ready = 1 → states 0,1,2,4,0. reg_write = 1 in state 4 with reg_dst = 0. flag_write = 1 in state 2.
- LW a454 with mem_ready low for 2 cycles in MEM_RD → states 0,1,5,6,6,6,7,0. reg_write and result_src = 1 only in state 7.
- SW 9c4c → mem_write = 1 with iord = 1 only in state 8. reg_write is never asserted.
- ADD with cz = 10 and carry = 0 → same 4 states; reg_write = 0 and flag_write = 0 throughout. Repeat with carry = 1 → reg_write = 1.
- BEQ with alu_zero = 1 in BRANCH → pc_write = 1 and pc_src = 1 in state 9. With alu_zero = 0 → pc_write = 0.
- Opcode 1111 → illegal = 1 in DECODE, then FETCH. With ILLEGAL_HALT_EN → state 15 held until reset is asserted mid-HALT, then state returns to 0.
